// File: rtl/timer_pkg.sv
// Shared types and default widths for the interval timer and its helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  localparam int TIMER_W  = 16;
  localparam int TIMER_CW = 8;

endpackage : timer_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/interval_timer.sv
// Programmable interval generator: counts t from 0 to f-1, once or repeatedly,
// with pause/stop control, wrap ticks, half-period flag and a wrap counter.
import timer_pkg::*;

module interval_timer #(
  parameter int W  = TIMER_W,
  parameter int CW = TIMER_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  f_in,
  input  logic          periodic,
  input  logic          pause,
  input  logic          stop,
  output logic [W-1:0]  t,
  output logic [W-1:0]  f,
  output logic          busy,
  output logic          tick,
  output logic          half,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] wraps
);

  timer_state_t state_q, state_d;
  logic [W-1:0] t_q, t_d;
  logic [W-1:0] f_q, f_d;
  logic         periodic_q, periodic_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         wraps_clr;
  logic         wraps_inc;

  logic         start_ok;
  logic         at_last;
  logic         wrap_now;

  // A wrap may still complete on the edge that enters HOLD, but a frozen
  // HOLD (pause still high) never wraps.
  assign start_ok = start && (f_in != '0);
  assign at_last  = (t_q == (f_q - W'(1)));
  assign wrap_now = !stop && at_last &&
                    ((state_q == RUN) || ((state_q == HOLD) && !pause));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      f_q        <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      f_q        <= f_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = RUN;
      end
      RUN, HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (wrap_now && !periodic_q) begin
          state_d = IDLE;
        end else begin
          state_d = pause ? HOLD : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t_d        = t_q;
    f_d        = f_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wraps_clr  = 1'b0;
    wraps_inc  = 1'b0;
    if (state_q == IDLE) begin
      if (start_ok) begin
        f_d        = f_in;
        periodic_d = periodic;
        t_d        = '0;
        wraps_clr  = 1'b1;
      end else if (start) begin
        err_d = 1'b1;
      end
    end else if (stop) begin
      t_d = '0;
    end else if (wrap_now) begin
      t_d       = '0;
      tick_d    = 1'b1;
      wraps_inc = 1'b1;
      done_d    = !periodic_q;
    end else if (!pause) begin
      t_d = t_q + W'(1);
    end
  end

  sat_counter #(
    .CW(CW)
  ) u_wraps (
    .clk  (clk),
    .rst  (rst),
    .clr  (wraps_clr),
    .inc  (wraps_inc),
    .count(wraps)
  );

  assign t    = t_q;
  assign f    = f_q;
  assign busy = (state_q != IDLE);
  assign tick = tick_q;
  assign done = done_q;
  assign err  = err_q;
  assign half = busy && (t_q >= (f_q >> 1));

endmodule : interval_timer
